slm_config_sequencer: RTL and testbench

Controller that sequences SLM configuration traffic between the PC RX FIFO, the SPI master and the PC TX serialiser. It pops one 32-bit command word at a time, runs one 16-bit SPI transaction per word, supervises completion with a timeout, and optionally returns a readback word to the PC. It sits under the data router's CONFIG mode and replaces ad-hoc per-cycle SPI handling with a fixed one-transaction-in-flight schedule.

---
 rtl/slm_config_sequencer.sv | 160 ++++++++++++++++
 tb/tb_slm_config_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slm_config_sequencer.sv
// Sequences SLM config words: pop one RX FIFO word, run one SPI transaction with a timeout
// guard, optionally return a readback word to the PC, then hold off for a fixed idle gap.
module slm_config_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 4,
  parameter int CNT_W          = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_rx_fifo_is_empty_sig,
  input  logic [31:0] i_rx_fifo_output_word,
  output logic        o_rx_fifo_next_word_cmd,
  output logic        o_enable_spi,
  output logic        o_start_spi_transfer_cmd,
  input  logic        i_transaction_complete,
  output logic [7:0]  o_Tx_Upper_Byte,
  output logic [7:0]  o_Tx_Lower_Byte,
  input  logic [7:0]  i_Rx_Upper_Byte,
  input  logic [7:0]  i_Rx_Lower_Byte,
  input  logic        i_serial_is_busy_sig,
  output logic [31:0] o_data_manager_output_data_word,
  output logic        o_data_manager_output_next_cmd,
  output logic        o_busy,
  output logic        o_timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_RESPOND,
    S_GAP
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_upper_q, tx_upper_d;
  logic [7:0]       tx_lower_q, tx_lower_d;
  logic             rb_flag_q, rb_flag_d;
  logic [31:0]      resp_q, resp_d;
  logic             timeout_err_q, timeout_err_d;
  logic             enable_spi_q;
  // Low for the first cycle after reset release so no pop can fire on that cycle.
  logic             run_q;

  logic pop;
  logic start;
  logic tx_go;

  logic unused_word_bits;
  assign unused_word_bits = ^i_rx_fifo_output_word[14:0];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tx_upper_d    = tx_upper_q;
    tx_lower_d    = tx_lower_q;
    rb_flag_d     = rb_flag_q;
    resp_d        = resp_q;
    timeout_err_d = timeout_err_q;
    pop           = 1'b0;
    start         = 1'b0;
    tx_go         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run_q && i_enable && !i_rx_fifo_is_empty_sig) begin
          pop        = 1'b1;
          tx_upper_d = i_rx_fifo_output_word[31:24];
          tx_lower_d = i_rx_fifo_output_word[23:16];
          rb_flag_d  = i_rx_fifo_output_word[15];
          state_d    = S_START;
        end
      end

      S_START: begin
        start   = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        // A completion arriving on the last allowed cycle still counts as success.
        if (i_transaction_complete) begin
          resp_d  = {i_Rx_Upper_Byte, i_Rx_Lower_Byte, 16'hFFFF};
          cnt_d   = '0;
          state_d = rb_flag_q ? S_RESPOND : S_GAP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_err_d = 1'b1;
          resp_d        = {tx_upper_q, 8'h00, 16'hEEEE};
          cnt_d         = '0;
          state_d       = S_RESPOND;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_RESPOND: begin
        if (!i_serial_is_busy_sig) begin
          tx_go   = 1'b1;
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      tx_upper_q    <= 8'h00;
      tx_lower_q    <= 8'h00;
      rb_flag_q     <= 1'b0;
      resp_q        <= 32'h0;
      timeout_err_q <= 1'b0;
      enable_spi_q  <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tx_upper_q    <= tx_upper_d;
      tx_lower_q    <= tx_lower_d;
      rb_flag_q     <= rb_flag_d;
      resp_q        <= resp_d;
      timeout_err_q <= timeout_err_d;
      enable_spi_q  <= i_enable || (state_q != S_IDLE);
      run_q         <= 1'b1;
    end
  end

  assign o_rx_fifo_next_word_cmd         = pop;
  assign o_start_spi_transfer_cmd        = start;
  assign o_data_manager_output_next_cmd  = tx_go;
  assign o_enable_spi                    = enable_spi_q;
  assign o_Tx_Upper_Byte                 = tx_upper_q;
  assign o_Tx_Lower_Byte                 = tx_lower_q;
  assign o_data_manager_output_data_word = resp_q;
  assign o_busy                          = (state_q != S_IDLE);
  assign o_timeout_err                   = timeout_err_q;

endmodule

// File: tb/tb_slm_config_sequencer.sv
// Bench for slm_config_sequencer: directed phases plus a randomized run, checked every cycle
// against a transaction-timeline model (pop -> start -> resolve -> respond -> gap -> idle).
module tb_slm_config_sequencer;
  localparam int T = 16;
  localparam int G = 4;

  logic        clk;
  logic        rst;
  logic        en, empty, complete, ser_busy;
  logic [31:0] head;
  logic [7:0]  rx_u, rx_l;
  logic        pop, en_spi, start, dm_next, busy, terr;
  logic [7:0]  tx_u, tx_l;
  logic [31:0] dm_word;

  slm_config_sequencer #(.TIMEOUT_CYCLES(T), .GAP_CYCLES(G), .CNT_W(16)) dut (
    .i_clock                         (clk),
    .i_reset                         (rst),
    .i_enable                        (en),
    .i_rx_fifo_is_empty_sig          (empty),
    .i_rx_fifo_output_word           (head),
    .o_rx_fifo_next_word_cmd         (pop),
    .o_enable_spi                    (en_spi),
    .o_start_spi_transfer_cmd        (start),
    .i_transaction_complete          (complete),
    .o_Tx_Upper_Byte                 (tx_u),
    .o_Tx_Lower_Byte                 (tx_l),
    .i_Rx_Upper_Byte                 (rx_u),
    .i_Rx_Lower_Byte                 (rx_l),
    .i_serial_is_busy_sig            (ser_busy),
    .o_data_manager_output_data_word (dm_word),
    .o_data_manager_output_next_cmd  (dm_next),
    .o_busy                          (busy),
    .o_timeout_err                   (terr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          d;   // completion delay after start; 0 = never completes
    logic [7:0]  ru;
    logic [7:0]  rl;
  } txn_t;

  int checks = 0;
  int failures = 0;

  logic [31:0] fifo_q[$];
  txn_t        txn_q[$];
  logic [31:0] exp_tx[$];
  txn_t        cur;

  int cyc = 0;
  int since_rst, last_start, busy_hold;
  int m_start_at, m_end_at, m_idle_at;
  bit m_idle, m_need_resp, m_tx_done, cur_to, m_err;
  bit en_prev, busy_prev, rand_busy, rand_en, noise_en;
  logic [15:0] m_bytes;
  logic [31:0] m_resp_word;
  int n_pop = 0, n_start = 0, n_tx = 0, n_push = 0, n_exp_tx = 0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    empty = (fifo_q.size() == 0);
    head  = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
  endtask

  task automatic push(input logic [31:0] w, input int d, input logic [7:0] ru, input logic [7:0] rl);
    txn_t t;
    t.word = w; t.d = d; t.ru = ru; t.rl = rl;
    fifo_q.push_back(w);
    txn_q.push_back(t);
    n_push++;
    if (d == 0 || d > T) begin
      exp_tx.push_back({w[31:24], 8'h00, 16'hEEEE});
      n_exp_tx++;
    end else if (w[15]) begin
      exp_tx.push_back({ru, rl, 16'hFFFF});
      n_exp_tx++;
    end
    drive_fifo();
  endtask

  task automatic model_reset();
    fifo_q.delete(); txn_q.delete(); exp_tx.delete();
    m_idle = 1; m_start_at = -1; m_end_at = -1; m_idle_at = -1;
    m_need_resp = 0; m_tx_done = 1; cur_to = 0; m_err = 0;
    m_bytes = 16'h0; m_resp_word = 32'h0;
    since_rst = 0; en_prev = 0; busy_prev = 0; last_start = -1; busy_hold = 0;
    cur.word = 32'h0; cur.d = 0; cur.ru = 8'h0; cur.rl = 8'h0;
    complete = 0; rx_u = 8'h0; rx_l = 8'h0; ser_busy = 0;
    drive_fifo();
  endtask

  task automatic chk_all_zero(input string tag);
    chk32({tag, "_outs"}, {pop, en_spi, start, dm_next, busy, terr, 2'b00, tx_u, tx_l, 8'h00}, 32'h0);
    chk32({tag, "_word"}, dm_word, 32'h0);
  endtask

  // One clock: check outputs at the negedge, then drive next-cycle inputs just after the posedge.
  task automatic cycle();
    bit exp_pop, exp_start, exp_tx_now, pop_now;
    logic [31:0] tmp;
    pop_now = 0;
    @(negedge clk);
    if (m_idle_at >= 0 && cyc == m_idle_at) begin
      m_idle = 1;
      m_idle_at = -1;
    end
    if (m_end_at >= 0 && cyc == m_end_at + 1) begin
      m_resp_word = cur_to ? {cur.word[31:24], 8'h00, 16'hEEEE} : {cur.ru, cur.rl, 16'hFFFF};
      if (cur_to) m_err = 1;
    end
    exp_pop    = m_idle && en && !empty && (since_rst > 0);
    exp_start  = (m_start_at >= 0) && (cyc == m_start_at);
    exp_tx_now = m_need_resp && !m_tx_done && (m_end_at >= 0) && (cyc > m_end_at) && !ser_busy;

    chk1("pop", pop, exp_pop);
    chk1("start", start, exp_start);
    chk1("tx_pulse", dm_next, exp_tx_now);
    chk1("busy", busy, !m_idle);
    chk1("timeout_err", terr, m_err);
    chk1("enable_spi", en_spi, en_prev || busy_prev);
    chk32("tx_bytes", {16'h0, tx_u, tx_l}, {16'h0, m_bytes});
    chk32("resp_word", dm_word, m_resp_word);

    if (pop) n_pop++;
    if (dm_next) n_tx++;
    if (start) begin
      n_start++;
      if (last_start >= 0) chk1("start_spacing", (cyc - last_start) >= (G + 3), 1'b1);
      last_start = cyc;
    end
    if (exp_tx_now) begin
      chk1("tx_expected_avail", exp_tx.size() > 0, 1'b1);
      if (exp_tx.size() > 0) chk32("tx_word", dm_word, exp_tx.pop_front());
      m_tx_done = 1;
      m_idle_at = cyc + G + 1;
    end

    en_prev   = en;
    busy_prev = !m_idle;
    if (exp_pop) begin
      cur         = txn_q.pop_front();
      pop_now     = 1;
      m_idle      = 0;
      m_start_at  = cyc + 1;
      cur_to      = (cur.d == 0 || cur.d > T);
      m_end_at    = m_start_at + (cur_to ? T : cur.d);
      m_need_resp = cur_to || cur.word[15];
      m_tx_done   = 0;
      m_idle_at   = m_need_resp ? -1 : m_end_at + G + 1;
      m_bytes     = cur.word[31:16];
    end

    @(posedge clk);
    #1;
    cyc++;
    since_rst++;
    if (pop_now) tmp = fifo_q.pop_front();
    drive_fifo();
    rx_u = cur.ru;
    rx_l = cur.rl;
    complete = (m_start_at >= 0 && !cur_to && cyc == m_start_at + cur.d) ||
               (noise_en && m_start_at >= 0 && cyc == m_start_at && $urandom_range(0, 1) == 1);
    if (busy_hold > 0) begin
      ser_busy = 1;
      busy_hold--;
    end else begin
      ser_busy = rand_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    if (rand_en) en = ($urandom_range(0, 7) != 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_wait_done(input int lead);
    for (int i = 0; i < 40; i++) begin
      if (!m_idle && m_start_at >= 0 && cyc >= m_start_at + lead) break;
      cycle();
    end
    chk1("reach_wait_done", !m_idle && m_start_at >= 0 && cyc >= m_start_at + lead, 1'b1);
  endtask

  initial begin
    int base_tx, base_pop, d;
    logic [31:0] w;
    rst = 1; en = 0; rand_busy = 0; rand_en = 0; noise_en = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_state");
    rst = 0;
    model_reset();

    // Enabled but empty FIFO: nothing may happen.
    en = 1;
    run(100);
    chk32("idle_pops", n_pop, 0);
    chk32("idle_starts", n_start, 0);
    chk32("idle_txs", n_tx, 0);

    // Readback word.
    push(32'h12348000, 10, 8'hAB, 8'hCD);
    run(40);
    chk32("rb_pops", n_pop, 1);
    chk32("rb_starts", n_start, 1);
    chk32("rb_txs", n_tx, 1);
    chk32("rb_bytes", {16'h0, tx_u, tx_l}, 32'h00001234);
    chk32("rb_word", dm_word, 32'hABCDFFFF);

    // No readback: no TX pulse.
    push(32'h56780000, 5, 8'h11, 8'h22);
    run(30);
    chk32("nrb_txs", n_tx, 1);
    chk1("nrb_idle", busy, 1'b0);

    // Three back-to-back words, one completing exactly on the timeout cycle.
    noise_en = 1;
    push(32'hA1B20000, 3, 8'h01, 8'h02);
    push(32'hC3D48000, T, 8'h5A, 8'hA5);
    push(32'hE5F60000, 1, 8'h33, 8'h44);
    run(120);
    noise_en = 0;
    chk32("b2b_pops", n_pop, 5);
    chk32("b2b_starts", n_start, 5);
    chk32("b2b_txs", n_tx, 2);
    chk1("b2b_no_err", terr, 1'b0);

    // Timeout, then a good word: error stays set.
    push(32'h9A000000, 0, 8'h00, 8'h00);
    run(40);
    chk1("to_err", terr, 1'b1);
    chk32("to_word", dm_word, 32'h9A00EEEE);
    push(32'h11228000, 4, 8'h77, 8'h88);
    run(40);
    chk1("err_sticky", terr, 1'b1);
    chk32("after_to_word", dm_word, 32'h7788FFFF);

    // Serial busy held well into RESPOND.
    base_tx = n_tx;
    busy_hold = 60;
    push(32'h2468C000, 2, 8'hDE, 8'hAD);
    run(90);
    chk32("busy_hold_tx", n_tx, base_tx + 1);

    // Enable dropped mid-WAIT_DONE.
    base_tx = n_tx;
    base_pop = n_pop;
    push(32'h13578000, 12, 8'hBE, 8'hEF);
    run_until_wait_done(3);
    en = 0;
    push(32'h0F0F8000, 2, 8'h01, 8'h01);
    run(50);
    chk32("endrop_tx", n_tx, base_tx + 1);
    chk32("endrop_pops", n_pop, base_pop + 1);
    en = 1;
    run(40);
    chk32("endrop_resume_pops", n_pop, base_pop + 2);

    // Randomized traffic.
    rand_busy = 1; rand_en = 1; noise_en = 1;
    for (int k = 0; k < 25; k++) begin
      w = $urandom;
      d = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, T));
      push(w, d, 8'($urandom), 8'($urandom));
      run($urandom_range(0, 30));
    end
    rand_busy = 0; rand_en = 0; noise_en = 0;
    en = 1;
    run(800);
    chk32("rand_pops", n_pop, n_push);
    chk32("rand_starts", n_start, n_push);
    chk32("rand_txs", n_tx, n_exp_tx);

    // Asynchronous reset mid-WAIT_DONE.
    push(32'h55AA8000, 0, 8'h00, 8'h00);
    run_until_wait_done(5);
    #2 rst = 1;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    run(30);
    chk1("post_reset_err", terr, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
